// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit_pkg
// Brief  : Shared funct3 codes, FSM state encoding and fault decode for the LSU.
// Rev    : 1.0
// ============================================================================
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_RD   = 2'd1,
        LSU_WR   = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Stores have no unsigned variants, so anything above F3_W is illegal for them.
    function automatic logic lsu_fault(input logic       is_store,
                                       input logic [2:0] f3,
                                       input logic [1:0] a_lo,
                                       input logic       align_chk);
        logic illegal;
        logic misaligned;
        if (is_store) begin
            illegal = (f3 > F3_W);
        end else begin
            illegal = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                        (f3 == F3_BU) || (f3 == F3_HU));
        end
        misaligned = ((f3[1:0] == 2'b01) && a_lo[0]) ||
                     ((f3[1:0] == 2'b10) && (a_lo != 2'b00));
        return illegal || (align_chk && misaligned);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_lane_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_lane_align
// Brief  : Little-endian sub-word merge for stores and extract/extend for loads.
// Rev    : 1.0
// ============================================================================
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword lane follows addr[1] only; addr[0] is either faulted or ignored upstream.
    always_comb begin
        byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        merged_o = word_i;
        load_o   = word_i;
        case (funct3_i[1:0])
            2'b00: begin
                merged_o[{addr_lo_i, 3'b000} +: 8] = store_data_i[7:0];
                load_o = funct3_i[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                if (addr_lo_i[1]) begin
                    merged_o[31:16] = store_data_i[15:0];
                end else begin
                    merged_o[15:0] = store_data_i[15:0];
                end
                load_o = funct3_i[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                merged_o = store_data_i;
                load_o   = word_i;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit
// Brief  : RV32I load/store stage with sub-word read-modify-write to word memory.
// Config : LSU_ALIGN_CHECK_EN - when defined, misaligned half/word accesses fault.
// Rev    : 1.0
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_fault,
    output logic        o_mem_stb,
    output logic        o_mem_wr_en,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_rd_ack,
    input  logic [31:0] i_mem_rdata
);

`ifdef LSU_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    lsu_state_e  state_q, state_d;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] store_data_q;
    logic [31:0] mem_addr_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data_q;
    logic        fault_q;

    logic        accept;
    logic        req_fault;
    logic [31:0] merged_word;
    logic [31:0] load_word;
    logic        unused_addr_hi;

    assign accept         = (state_q == LSU_IDLE) && i_valid;
    assign req_fault      = lsu_fault(i_is_store, i_funct3, i_addr[1:0], ALIGN_CHECK);
    assign unused_addr_hi = ^i_addr[31:MEM_AW+2];

    lsu_lane_align u_lane_align (
        .word_i       (i_mem_rdata),
        .addr_lo_i    (addr_lo_q),
        .store_data_i (store_data_q),
        .funct3_i     (funct3_q),
        .merged_o     (merged_word),
        .load_o       (load_word)
    );

    always_comb begin
        state_d     = state_q;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_mem_stb   = 1'b0;
        o_mem_wr_en = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (i_valid) begin
                    if (req_fault) begin
                        state_d = LSU_DONE;
                    end else if (!i_is_store || (i_funct3 != F3_W)) begin
                        state_d = LSU_RD;
                    end else begin
                        state_d = LSU_WR;
                    end
                end
            end
            LSU_RD: begin
                o_busy    = 1'b1;
                o_mem_stb = 1'b1;
                if (i_mem_rd_ack) begin
                    state_d = is_store_q ? LSU_WR : LSU_DONE;
                end
            end
            LSU_WR: begin
                o_busy      = 1'b1;
                o_mem_wr_en = 1'b1;
                state_d     = LSU_DONE;
            end
            LSU_DONE: begin
                o_done  = 1'b1;
                state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= LSU_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
            store_data_q <= 32'h0;
            mem_addr_q   <= 32'h0;
            wdata_q      <= 32'h0;
            load_data_q  <= 32'h0;
            fault_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_store_q   <= i_is_store;
                funct3_q     <= i_funct3;
                addr_lo_q    <= i_addr[1:0];
                store_data_q <= i_store_data;
                mem_addr_q   <= {{(32-MEM_AW){1'b0}}, i_addr[MEM_AW+1:2]};
                wdata_q      <= i_store_data;
                fault_q      <= req_fault;
                if (req_fault) begin
                    load_data_q <= 32'h0;
                end
            end
            // Read data is consumed on the ack edge: merged for stores, extended for loads.
            if ((state_q == LSU_RD) && i_mem_rd_ack) begin
                if (is_store_q) begin
                    wdata_q <= merged_word;
                end else begin
                    load_data_q <= load_word;
                end
            end
        end
    end

    assign o_load_data = load_data_q;
    assign o_fault     = o_done && fault_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Scoreboard bench for load_store_unit with a word memory and reference model.
// Rev    : 1.0
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_is_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_store_data;
    logic        o_busy, o_done, o_fault, o_mem_stb, o_mem_wr_en;
    logic [31:0] o_load_data, o_mem_addr, o_mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    int          stall;
    int          stb_cnt;
    logic        pre_we;
    int          pre_idx;
    logic [31:0] pre_val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          fault;
        bit          is_load;
        logic [31:0] ldata;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          n_stb;
        int          n_wr;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_AW(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .i_is_store   (i_is_store),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_store_data (i_store_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_load_data  (o_load_data),
        .o_fault      (o_fault),
        .o_mem_stb    (o_mem_stb),
        .o_mem_wr_en  (o_mem_wr_en),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rd_ack (mem_ack),
        .i_mem_rdata  (mem_rdata)
    );

    // Word memory: combinational read, ack after 'stall' strobe cycles.
    assign mem_rdata = mem[o_mem_addr[9:0]];
    assign mem_ack   = o_mem_stb && (stb_cnt >= stall);

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        if (o_mem_wr_en) mem[o_mem_addr[9:0]] <= o_mem_wdata;
        if (o_mem_stb && !mem_ack) stb_cnt <= stb_cnt + 1;
        else stb_cnt <= 0;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endfunction

    // Reference model: RV32I load/store semantics on a plain word array.
    function automatic exp_t model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] d, input int stl);
        exp_t        e;
        int          idx;
        int          sz;
        int          off;
        bit          uns;
        bit          illegal;
        bit          mis;
        logic [31:0] word, v, mask;
        idx     = int'(a[11:2]);
        word    = ref_mem[idx];
        sz      = int'(f3[1:0]);
        uns     = f3[2];
        illegal = st ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
        mis     = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        mis = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
`endif
        e.fault   = illegal || mis;
        e.is_load = !st;
        e.waddr   = 32'(idx);
        e.wdata   = 32'h0;
        e.ldata   = 32'h0;
        e.n_stb   = 0;
        e.n_wr    = 0;
        off       = (sz == 0) ? int'(a[1:0]) : (sz == 1) ? 2 * int'(a[1]) : 0;
        if (e.fault) begin
            e.lat = 1;
        end else if (!st) begin
            if (sz == 0) begin
                v = (word >> (8 * off)) & 32'hFF;
                if (!uns && v >= 128) v = v + 32'hFFFFFF00;
            end else if (sz == 1) begin
                v = (word >> (8 * off)) & 32'hFFFF;
                if (!uns && v >= 32768) v = v + 32'hFFFF0000;
            end else begin
                v = word;
            end
            e.ldata = v;
            e.n_stb = stl + 1;
            e.lat   = 2 + stl;
        end else begin
            e.n_wr = 1;
            if (sz == 2) begin
                e.wdata = d;
                e.lat   = 2;
            end else begin
                mask    = (sz == 0) ? 32'hFF : 32'hFFFF;
                e.wdata = (word & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
                e.n_stb = stl + 1;
                e.lat   = 3 + stl;
            end
            ref_mem[idx] = e.wdata;
        end
        return e;
    endfunction

    // Monitor: matches memory-side activity and completions against the scoreboard.
    initial begin
        int m_stb;
        int m_wr;
        exp_t e;
        m_stb = 0;
        m_wr  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_stb = 0;
                m_wr  = 0;
            end else begin
                if (o_mem_stb || o_mem_wr_en) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_mem_access stb=%0b wr_en=%0b required=0", o_mem_stb, o_mem_wr_en);
                    end else begin
                        if (o_mem_stb) m_stb++;
                        if (o_mem_wr_en) begin
                            m_wr++;
                            chk("mem_wdata", o_mem_wdata, sb[0].wdata);
                        end
                        chk("mem_addr", o_mem_addr, sb[0].waddr);
                    end
                end
                if (o_done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done actual=1 required=0");
                    end else begin
                        e = sb.pop_front();
                        chk("fault", 32'(o_fault), 32'(e.fault));
                        if (e.is_load || e.fault) chk("load_data", o_load_data, e.ldata);
                        chk("stb_cycles", 32'(m_stb), 32'(e.n_stb));
                        chk("wr_en_cycles", 32'(m_wr), 32'(e.n_wr));
                    end
                    m_stb = 0;
                    m_wr  = 0;
                end
            end
        end
    end

    task automatic send(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input int stl, output int waited, output int exp_lat);
        exp_t e;
        @(negedge clk);
        i_valid      = 1'b1;
        i_is_store   = st;
        i_funct3     = f3;
        i_addr       = a;
        i_store_data = d;
        stall        = stl;
        waited       = 0;
        while (o_busy || o_done) begin
            if (waited >= 60) begin
                $display("FAIL accept_timeout actual=%0d cycles required<60", waited);
                $fatal(1);
            end
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        e = model(st, f3, a, d, stl);
        sb.push_back(e);
        exp_lat = e.lat;
    endtask

    task automatic finish_req(input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) i_valid = 1'b0;
            lat++;
            if (lat > 60) begin
                $display("FAIL done_timeout actual=%0d cycles required=%0d", lat, exp_lat);
                $fatal(1);
            end
        end while (!o_done);
        chk("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int stl);
        int w, l;
        send(st, f3, a, d, stl, w, l);
        finish_req(l);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},      32'(o_busy),      32'h0);
        chk({tag, "_done"},      32'(o_done),      32'h0);
        chk({tag, "_fault"},     32'(o_fault),     32'h0);
        chk({tag, "_stb"},       32'(o_mem_stb),   32'h0);
        chk({tag, "_wr_en"},     32'(o_mem_wr_en), 32'h0);
        chk({tag, "_load_data"}, o_load_data,      32'h0);
        chk({tag, "_mem_addr"},  o_mem_addr,       32'h0);
        chk({tag, "_mem_wdata"}, o_mem_wdata,      32'h0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog_timeout actual=expired required=finish");
        $fatal(1);
    end

    initial begin
        int          w, la, lb;
        logic [31:0] saved, a, r;
        rst_n        = 1'b0;
        i_valid      = 1'b0;
        i_is_store   = 1'b0;
        i_funct3     = 3'b000;
        i_addr       = 32'h0;
        i_store_data = 32'h0;
        stall        = 0;
        pre_we       = 1'b0;
        pre_idx      = 0;
        pre_val      = 32'h0;

        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            pre_we  = 1'b1;
            pre_idx = i;
            pre_val = (i == 5) ? 32'h8899AABB : $urandom;
            ref_mem[i] = pre_val;
        end
        @(negedge clk);
        pre_we = 1'b0;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sub-word loads from a known word
        txn(1'b0, 3'b000, 32'h16, 32'h0, 0);
        txn(1'b0, 3'b100, 32'h16, 32'h0, 0);
        txn(1'b0, 3'b001, 32'h14, 32'h0, 0);
        txn(1'b0, 3'b101, 32'h16, 32'h0, 0);
        // Word store, then sub-word read-modify-writes on the same word
        txn(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 0);
        txn(1'b0, 3'b010, 32'h20, 32'h0, 0);
        txn(1'b1, 3'b000, 32'h21, 32'h000000A5, 0);
        txn(1'b1, 3'b001, 32'h22, 32'h00001234, 0);
        txn(1'b0, 3'b010, 32'h20, 32'h0, 0);
        // Misaligned halfword store, misaligned word load, illegal funct3
        txn(1'b1, 3'b001, 32'h21, 32'h0000CAFE, 0);
        txn(1'b0, 3'b010, 32'h20, 32'h0, 0);
        txn(1'b0, 3'b010, 32'h23, 32'h0, 0);
        txn(1'b0, 3'b011, 32'h20, 32'h0, 0);
        txn(1'b0, 3'b111, 32'h20, 32'h0, 0);
        txn(1'b1, 3'b100, 32'h20, 32'h11111111, 0);
        txn(1'b0, 3'b010, 32'h20, 32'h0, 0);
        // Upper address bits wrap away
        txn(1'b0, 3'b000, 32'hFFFFF016, 32'h0, 1);

        // Reset while an SB is waiting in RD
        saved = ref_mem[16];
        send(1'b1, 3'b000, 32'h41, 32'h0000005A, 5, w, la);
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        sb.delete();
        ref_mem[16] = saved;
        stall = 0;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_mem_unchanged", mem[16], saved);

        // Back-to-back: valid stays high, second request waits for completion
        send(1'b0, 3'b010, 32'h20, 32'h0, 0, w, la);
        send(1'b0, 3'b001, 32'h16, 32'h0, 0, w, lb);
        chk("b2b_accept_gap", 32'(w), 32'(la));
        finish_req(lb);
        send(1'b1, 3'b000, 32'h30, 32'h77, 0, w, la);
        send(1'b0, 3'b000, 32'h30, 32'h0, 0, w, lb);
        chk("b2b_accept_gap_sb", 32'(w), 32'(la));
        finish_req(lb);

        // Randomized traffic over a small window with random memory stalls
        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            a = (r & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < 1024; i++) begin
            if (mem[i] !== ref_mem[i]) chk("mem_word", mem[i], ref_mem[i]);
            else checks++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
